// File: rtl/cache_pkg.sv
// ============================================================================
// Module : cache_pkg
// Desc   : Shared types and constants for the dcache write-back buffer and
//          its AXI master port.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int          WB_LINE_WIDTH    = 256;
  localparam int          LINE_BYTE_OFFSET = $clog2(WB_LINE_WIDTH / 8);
  localparam logic [1:0]  AXI_BURST_INCR   = 2'b01;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_AW   = 2'd1,
    WB_W    = 2'd2,
    WB_B    = 2'd3
  } wb_state_t;

  // Layout of one buffer entry for the default line size.
  typedef struct packed {
    logic                           valid;
    logic [31-LINE_BYTE_OFFSET:0]   tag;
    logic [WB_LINE_WIDTH-1:0]       data;
  } wb_entry_t;

  typedef struct packed {
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        bready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        rready;
  } axi_req_t;

  typedef struct packed {
    logic        awready;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
  } axi_resp_t;

endpackage

`default_nettype wire

// File: rtl/dcache_wb_buffer.sv
// ============================================================================
// Module : dcache_wb_buffer
// Desc   : Queues evicted dirty lines, drains each as one AXI INCR write burst
//          and forwards queued data to lookups. Optional macro WB_MERGE_EN
//          merges pushes into a matching queued (not in-flight) entry.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_wb_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [31:0]           push_addr,
  input  logic [LINE_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  empty,
  input  logic [31:0]           lookup_addr,
  output logic                  lookup_hit,
  output logic [LINE_WIDTH-1:0] lookup_data,
  output axi_req_t              axi_req,
  input  axi_resp_t             axi_resp
);

  localparam int BEATS = LINE_WIDTH / 32;
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int TW    = 32 - OFF;
  localparam int PW    = $clog2(DEPTH);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] ST_IDLE = WB_IDLE;
  localparam logic [1:0] ST_AW   = WB_AW;
  localparam logic [1:0] ST_W    = WB_W;
  localparam logic [1:0] ST_B    = WB_B;

  logic [DEPTH-1:0]      valid;
  logic [TW-1:0]         tag  [DEPTH];
  logic [LINE_WIDTH-1:0] data [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           count;
  logic [BW-1:0]         beat;
  logic [1:0]            state;

  logic [TW-1:0]         push_tag;
  logic                  in_flight;
  logic                  merge_hit;
  logic [PW-1:0]         merge_idx;
  logic                  do_alloc;
  logic                  do_pop;
  logic                  wr_en;
  logic [PW-1:0]         wr_idx;
  logic                  last_beat;
  logic                  unused_ok;

  assign push_tag  = push_addr[31:OFF];
  assign in_flight = (state != ST_IDLE);
  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0) && (state == ST_IDLE);
  assign last_beat = (beat == BW'(BEATS - 1));
  assign unused_ok = ^{push_addr[OFF-1:0], lookup_addr[OFF-1:0], axi_resp};

`ifdef WB_MERGE_EN
  // The head is excluded while its burst is running: its data is already on the bus.
  always_comb begin : merge_search
    logic [PW-1:0] idx;
    idx       = '0;
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (tag[idx] == push_tag) && !(in_flight && (idx == head))) begin
        merge_hit = 1'b1;
        merge_idx = idx;
      end
    end
  end
`else
  assign merge_hit = 1'b0;
  assign merge_idx = '0;
`endif

  assign do_alloc = push && !merge_hit && !full;
  assign do_pop   = (state == ST_B) && axi_resp.bvalid;
  assign wr_en    = do_alloc || (push && merge_hit);
  assign wr_idx   = merge_hit ? merge_idx : tail;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[wr_idx]  <= push_tag;
      data[wr_idx] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      case ({do_alloc, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      beat  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          beat <= '0;
          if (count != '0) state <= ST_AW;
        end
        ST_AW: begin
          if (axi_resp.awready) state <= ST_W;
        end
        ST_W: begin
          if (axi_resp.wready) begin
            if (last_beat) begin
              beat  <= '0;
              state <= ST_B;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
        default: begin
          if (axi_resp.bvalid) state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    axi_req = '0;
    if (state == ST_AW) begin
      axi_req.awvalid = 1'b1;
      axi_req.awaddr  = {tag[head], OFF'(0)};
      axi_req.awlen   = 8'(BEATS - 1);
      axi_req.awsize  = 3'd2;
      axi_req.awburst = AXI_BURST_INCR;
      axi_req.awid    = 4'd0;
    end
    if (state == ST_W) begin
      axi_req.wvalid = 1'b1;
      axi_req.wstrb  = 4'hF;
      axi_req.wdata  = data[head][32*beat +: 32];
      axi_req.wlast  = last_beat;
    end
    axi_req.bready = (state == ST_B);
  end

  // Scan oldest to youngest so the entry nearest the tail wins.
  always_comb begin : fwd_mux
    logic [PW-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (tag[idx] == lookup_addr[31:OFF])) begin
        lookup_hit  = 1'b1;
        lookup_data = data[idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_wb_buffer.sv
// ============================================================================
// Module : tb_dcache_wb_buffer
// Desc   : Directed testbench for dcache_wb_buffer with a reactive AXI slave.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dcache_wb_buffer;
  import cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         push = 1'b0;
  logic [31:0]  push_addr = '0;
  logic [255:0] push_data = '0;
  logic         full, empty, lookup_hit;
  logic [31:0]  lookup_addr = '0;
  logic [255:0] lookup_data;
  axi_req_t     req;
  axi_resp_t    resp = '0;

  int checks = 0;
  int errors = 0;

  // slave controls and observations
  logic         aw_stall = 1'b0;
  logic         w_alt    = 1'b0;
  int           bdelay   = 1;
  int           b_due    = 0;
  logic         b_hs     = 1'b0;
  int           cur_beat = 0;
  logic [31:0]  cur_addr = '0;
  logic [255:0] cur_line = '0;
  logic         hold_valid = 1'b0;
  logic [31:0]  hold_data  = '0;
  logic [31:0]  bq_addr[$];
  logic [255:0] bq_data[$];

  dcache_wb_buffer #(.DEPTH(2), .LINE_WIDTH(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .full        (full),
    .empty       (empty),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .axi_req     (req),
    .axi_resp    (resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mkline(input logic [7:0] s);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {s, 8'(i), s, 8'(i)};
    return l;
  endfunction

  function automatic logic [255:0] ramp();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h11111111 * (i + 1);
    return l;
  endfunction

  // AXI slave: sets responses at each falling edge and records the handshakes
  // that will occur at the following rising edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      resp = '0; b_due = 0; b_hs = 1'b0; cur_beat = 0; hold_valid = 1'b0;
    end else begin
      if (b_hs) begin resp.bvalid = 1'b0; b_hs = 1'b0; end
      if (b_due > 0) begin
        b_due--;
        if (b_due == 0) resp.bvalid = 1'b1;
      end
      resp.awready = !aw_stall;
      resp.wready  = w_alt ? !resp.wready : 1'b1;
      if (req.awvalid && resp.awready) begin
        cur_addr = req.awaddr; cur_beat = 0;
        chk("awlen", 256'(req.awlen), 256'd7);
        chk("awsize_burst", 256'({req.awsize, req.awburst}), 256'({3'd2, 2'd1}));
      end
      if (req.wvalid) begin
        if (hold_valid) chk("wdata_hold", 256'(req.wdata), 256'(hold_data));
        hold_valid = !resp.wready;
        hold_data  = req.wdata;
      end
      if (req.wvalid && resp.wready) begin
        if (cur_beat < 8) cur_line[cur_beat*32 +: 32] = req.wdata;
        chk("wlast", 256'(req.wlast), 256'(cur_beat == 7));
        cur_beat++;
        if (req.wlast || cur_beat >= 8) begin
          bq_addr.push_back(cur_addr);
          bq_data.push_back(cur_line);
          cur_beat = 0;
          b_due = bdelay;
        end
      end
      if (resp.bvalid && req.bready) b_hs = 1'b1;
    end
  end

  task automatic do_push(input logic [31:0] a, input logic [255:0] d);
    push = 1'b1; push_addr = a; push_data = d;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    int n;
    n = 0;
    while (!(empty && !resp.bvalid) && n < max) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", 256'(n >= max), 256'd0);
  endtask

  task automatic check_bursts(input int n, input logic [31:0] a0, input logic [255:0] d0,
                              input logic [31:0] a1, input logic [255:0] d1);
    chk("burst_count", 256'(bq_addr.size()), 256'(n));
    if (n >= 1 && bq_addr.size() >= 1) begin
      chk("burst0_addr", 256'(bq_addr[0]), 256'(a0));
      chk("burst0_data", bq_data[0], d0);
    end
    if (n >= 2 && bq_addr.size() >= 2) begin
      chk("burst1_addr", 256'(bq_addr[1]), 256'(a1));
      chk("burst1_data", bq_data[1], d1);
    end
    bq_addr.delete();
    bq_data.delete();
  endtask

  typedef struct {
    logic        do_push;
    logic [31:0] addr;
    logic [7:0]  seed;
    logic [31:0] laddr;
    logic        exp_hit;
    logic [7:0]  exp_seed;
    logic        exp_full;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[5];
  int   n;

  initial begin
    vecs[0] = '{1'b1, 32'h00, 8'hA1, 32'h00, 1'b1, 8'hA1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h20, 8'hB2, 32'h3C, 1'b1, 8'hB2, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h60, 8'hC3, 32'h60, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h00, 8'h00, 32'h1F, 1'b1, 8'hA1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h00, 8'h00, 32'h40, 1'b0, 8'h00, 1'b1, 1'b0};

    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_full", 256'(full), 256'd0);
    chk("rst_empty", 256'(empty), 256'd1);
    chk("rst_hit", 256'(lookup_hit), 256'd0);
    chk("rst_ldata", lookup_data, 256'd0);
    chk("rst_axi", 256'({req.awvalid, req.wvalid, req.bready, req.wlast}), 256'd0);
    rst_n = 1'b1;

    // table: fill with AW stalled, probe lookup/full/empty
    aw_stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_push) do_push(vecs[i].addr, mkline(vecs[i].seed));
      else @(negedge clk);
      lookup_addr = vecs[i].laddr;
      #1;
      chk($sformatf("v%0d_hit", i), 256'(lookup_hit), 256'(vecs[i].exp_hit));
      chk($sformatf("v%0d_data", i), lookup_data,
          vecs[i].exp_hit ? mkline(vecs[i].exp_seed) : 256'd0);
      chk($sformatf("v%0d_full", i), 256'(full), 256'(vecs[i].exp_full));
      chk($sformatf("v%0d_empty", i), 256'(empty), 256'(vecs[i].exp_empty));
    end
    aw_stall = 1'b0;
    wait_empty(200);
    check_bursts(2, 32'h00, mkline(8'hA1), 32'h20, mkline(8'hB2));

    // single push latency with an always-ready slave
    @(negedge clk);
    do_push(32'h40, ramp());
    #1;
    chk("t1_awvalid_n", 256'(req.awvalid), 256'd0);
    chk("t1_empty_n", 256'(empty), 256'd0);
    @(negedge clk); #1;
    chk("t1_awvalid_n1", 256'(req.awvalid), 256'd1);
    chk("t1_awaddr", 256'(req.awaddr), 256'h40);
    repeat (9) @(negedge clk);
    #1;
    chk("t1_empty_n10", 256'(empty), 256'd0);
    @(negedge clk); #1;
    chk("t1_empty_n11", 256'(empty), 256'd1);
    wait_empty(100);
    check_bursts(1, 32'h40, ramp(), 32'h0, 256'd0);

    // same line pushed twice before draining
    aw_stall = 1'b1;
    do_push(32'h80, mkline(8'h0A));
    do_push(32'h80, mkline(8'h0B));
    lookup_addr = 32'h84;
    #1;
    chk("t3_hit", 256'(lookup_hit), 256'd1);
    chk("t3_data", lookup_data, mkline(8'h0B));
`ifdef WB_MERGE_EN
    chk("t3_full", 256'(full), 256'd0);
`else
    chk("t3_full", 256'(full), 256'd1);
`endif
    aw_stall = 1'b0;
    wait_empty(200);
`ifdef WB_MERGE_EN
    check_bursts(1, 32'h80, mkline(8'h0B), 32'h0, 256'd0);
`else
    check_bursts(2, 32'h80, mkline(8'h0A), 32'h80, mkline(8'h0B));
`endif

    // alternate-cycle wready and a late bvalid
    w_alt = 1'b1;
    bdelay = 3;
    lookup_addr = 32'h100;
    do_push(32'h100, mkline(8'h5E));
    n = 0;
    while (!req.bready && n < 100) begin @(negedge clk); #1; n++; end
    chk("t4_reach_b", 256'(req.bready), 256'd1);
    n = 0;
    while (!resp.bvalid && n < 10) begin
      chk("t4_hold_hit", 256'(lookup_hit), 256'd1);
      chk("t4_hold_empty", 256'(empty), 256'd0);
      @(negedge clk); #1; n++;
    end
    chk("t4_bvalid", 256'(resp.bvalid), 256'd1);
    @(negedge clk); #1;
    chk("t4_popped", 256'(empty), 256'd1);
    chk("t4_miss", 256'(lookup_hit), 256'd0);
    w_alt = 1'b0;
    bdelay = 1;
    wait_empty(100);
    check_bursts(1, 32'h100, mkline(8'h5E), 32'h0, 256'd0);

    // reset on the 4th W beat with two lines queued
    @(negedge clk);
    do_push(32'h200, mkline(8'h21));
    do_push(32'h220, mkline(8'h22));
    lookup_addr = 32'h220;
    n = 0;
    #1;
    while (!(req.wvalid && cur_beat == 4) && n < 100) begin @(negedge clk); #1; n++; end
    chk("t5_beat4", 256'(cur_beat), 256'd4);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("t5_awvalid", 256'(req.awvalid), 256'd0);
    chk("t5_wvalid", 256'(req.wvalid), 256'd0);
    chk("t5_empty", 256'(empty), 256'd1);
    chk("t5_full", 256'(full), 256'd0);
    chk("t5_hit", 256'(lookup_hit), 256'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("t5_still_empty", 256'(empty), 256'd1);
    check_bursts(0, 32'h0, 256'd0, 32'h0, 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
